// File: rtl/program_loader_if.sv
// Loader-side bus: UART receive strobe, load request, program-memory write
// port, status flags and the ACK/NAK byte for the UART transmitter.
interface program_loader_if #(
  parameter int CANT_BITS_ADDR     = 11,
  parameter int RAM_WIDTH_PROGRAMA = 32
) ();
  logic                          i_load_request;
  logic [7:0]                    i_rx_data;
  logic                          i_rx_valid;
  logic [CANT_BITS_ADDR-1:0]     o_addr_mem_programa;
  logic [RAM_WIDTH_PROGRAMA-1:0] o_data_mem_programa;
  logic                          o_write_read_mem;
  logic                          o_enable_mem;
  logic                          o_control_mux_addr_mem;
  logic                          o_busy;
  logic                          o_done;
  logic                          o_error;
  logic                          o_ack_valid;
  logic [7:0]                    o_ack_data;
  logic [CANT_BITS_ADDR:0]       o_word_count;

  // Side that drives bytes and requests (UART receiver / control logic)
  modport master (
    output i_load_request, i_rx_data, i_rx_valid,
    input  o_addr_mem_programa, o_data_mem_programa, o_write_read_mem,
           o_enable_mem, o_control_mux_addr_mem, o_busy, o_done, o_error,
           o_ack_valid, o_ack_data, o_word_count
  );

  // The loader itself
  modport slave (
    input  i_load_request, i_rx_data, i_rx_valid,
    output o_addr_mem_programa, o_data_mem_programa, o_write_read_mem,
           o_enable_mem, o_control_mux_addr_mem, o_busy, o_done, o_error,
           o_ack_valid, o_ack_data, o_word_count
  );
endinterface

// File: rtl/program_loader.sv
// Serial program loader: 16-bit big-endian word-count header, then
// big-endian 32-bit instructions written to program memory from address 0.
// Finishes with an ACK (0x06) or NAK (0x15) strobe. Every output decodes
// from registers, so nothing combinational reaches the fetch stage.
module program_loader #(
  parameter int RAM_WIDTH_PROGRAMA = 32,
  parameter int RAM_DEPTH_PROGRAMA = 2048,
  parameter int CANT_BITS_ADDR     = 11,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int TIMEOUT_BITS       = 20
) (
  input  logic           i_clock,
  input  logic           i_soft_reset,
  program_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, FAIL} state_t;

  localparam logic [7:0]              ACK_BYTE = 8'h06;
  localparam logic [7:0]              NAK_BYTE = 8'h15;
  localparam logic [15:0]             DEPTH    = 16'(RAM_DEPTH_PROGRAMA);
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  state_t                        state;
  logic [7:0]                    cnt_hi;
  logic [15:0]                   count;
  logic [23:0]                   word_lo;    // first three bytes of the word in flight
  logic [1:0]                    byte_idx;
  logic [CANT_BITS_ADDR-1:0]     addr;
  logic [CANT_BITS_ADDR:0]       word_count;
  logic [RAM_WIDTH_PROGRAMA-1:0] data;
  logic                          done;
  logic                          err;
  logic [TIMEOUT_BITS-1:0]       tmo;

  logic [15:0] count_in;
  logic [15:0] written_next;
  logic        tmo_hit;
  logic        busy;

  assign count_in     = {cnt_hi, bus.i_rx_data};
  assign written_next = 16'(word_count) + 16'd1;
  assign tmo_hit      = (tmo == TMO_LAST);

  // Load sequencer: header capture, word assembly, write strobe, ACK/NAK.
  // The inter-byte timeout counter restarts on every state change and byte.
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state      <= IDLE;
      addr       <= '0;
      word_count <= '0;
      data       <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      byte_idx   <= '0;
      tmo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_load_request) begin
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            addr       <= '0;
            byte_idx   <= '0;
            tmo        <= '0;
            state      <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (bus.i_rx_valid) begin
            cnt_hi <= bus.i_rx_data;
            tmo    <= '0;
            state  <= CNT_LO;
          end else if (tmo_hit) begin
            tmo   <= '0;
            state <= FAIL;
          end else begin
            tmo <= tmo + TIMEOUT_BITS'(1);
          end
        end
        CNT_LO: begin
          if (bus.i_rx_valid) begin
            count <= count_in;
            tmo   <= '0;
            state <= (count_in == 16'd0 || count_in > DEPTH) ? FAIL : DATA;
          end else if (tmo_hit) begin
            tmo   <= '0;
            state <= FAIL;
          end else begin
            tmo <= tmo + TIMEOUT_BITS'(1);
          end
        end
        DATA: begin
          if (bus.i_rx_valid) begin
            word_lo <= {word_lo[15:0], bus.i_rx_data};
            tmo     <= '0;
            if (byte_idx == 2'd3) begin
              data     <= RAM_WIDTH_PROGRAMA'({word_lo, bus.i_rx_data});
              byte_idx <= 2'd0;
              state    <= WRITE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end else if (tmo_hit) begin
            tmo   <= '0;
            state <= FAIL;
          end else begin
            tmo <= tmo + TIMEOUT_BITS'(1);
          end
        end
        WRITE: begin
          // A byte landing in the write cycle starts the next word.
          addr       <= addr + CANT_BITS_ADDR'(1);
          word_count <= word_count + (CANT_BITS_ADDR+1)'(1);
          tmo        <= '0;
          if (bus.i_rx_valid) begin
            word_lo  <= {word_lo[15:0], bus.i_rx_data};
            byte_idx <= 2'd1;
          end
          state <= (written_next == count) ? DONE : DATA;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        FAIL: begin
          err   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CNT_HI) || (state == CNT_LO) ||
                (state == DATA)   || (state == WRITE);

  assign bus.o_addr_mem_programa    = addr;
  assign bus.o_data_mem_programa    = data;
  assign bus.o_write_read_mem       = (state == WRITE);
  assign bus.o_enable_mem           = (state == WRITE);
  assign bus.o_busy                 = busy;
  assign bus.o_control_mux_addr_mem = busy;
  assign bus.o_done                 = done;
  assign bus.o_error                = err;
  assign bus.o_ack_valid            = (state == DONE) || (state == FAIL);
  assign bus.o_ack_data             = (state == DONE) ? ACK_BYTE :
                                      (state == FAIL) ? NAK_BYTE : 8'h00;
  assign bus.o_word_count           = word_count;
endmodule
